// File: rtl/logic_unit_arbiter_pkg.sv
// Shared op-code constants and FSM state encoding for the two-port logic unit arbiter.
package logic_unit_arbiter_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/logic_unit_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: on contention, the requester not granted last time wins.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (en) begin
            case (valid)
                2'b01: grant = 2'b01;
                2'b10: begin
                    grant    = 2'b10;
                    grant_id = 1'b1;
                end
                2'b11: begin
                    if (last_grant) begin
                        grant = 2'b01;
                    end else begin
                        grant    = 2'b10;
                        grant_id = 1'b1;
                    end
                end
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one combinational logic unit between two requesters: accept, one settle cycle, then hold the response.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int OP_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    output logic [OP_W-1:0]  lu_op,
    input  logic [WIDTH-1:0] lu_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err
);

    state_t     state;
    logic       last_grant;
    logic [1:0] grant;
    logic       grant_id;
    logic       accept;
    logic       illegal;

    rr_arbiter2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .en         (state == IDLE),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;
    assign illegal    = (lu_op == OP_W'(OP_ILL));
    assign resp_valid = (state == RESP);

    // lu_* are loaded only at accept, so they stay put for the whole settle cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lu_a       <= '0;
            lu_b       <= '0;
            lu_op      <= '0;
            resp_data  <= '0;
            resp_id    <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= EXEC;
                        last_grant <= grant_id;
                        resp_id    <= grant_id;
                        lu_a       <= grant_id ? req1_a  : req0_a;
                        lu_b       <= grant_id ? req1_b  : req0_b;
                        lu_op      <= grant_id ? req1_op : req0_op;
                    end
                end
                EXEC: begin
                    state     <= RESP;
                    resp_err  <= illegal;
                    resp_data <= illegal ? '0 : lu_out;
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
